// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and types for the VGA timing generator and renderer.
package vga_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int CNT_W     = 10;
    localparam int CNT_LIMIT = 1 << CNT_W;
    localparam int COLOR_W   = 4;

    // Timing terms that travel alongside the renderer's colour; syncs are active-low.
    typedef struct packed {
        logic active;
        logic hsync_n;
        logic vsync_n;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{active: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

endpackage

// File: rtl/sync_delay.sv
// Shift pipeline of DEPTH registers with asynchronous reset to RST_VAL; DEPTH=0 is a wire.
module sync_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             px_clk,
    input  logic             reset_ni,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    localparam int N = (DEPTH > 0) ? DEPTH : 1;

    logic [WIDTH-1:0] stg [N];

    always_ff @(posedge px_clk or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < N; i++) stg[i] <= RST_VAL;
        end else begin
            stg[0] <= d;
            for (int i = 1; i < N; i++) stg[i] <= stg[i-1];
        end
    end

    // With DEPTH=0 the single stage is dead and gets trimmed.
    assign q = (DEPTH == 0) ? d : stg[N-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters, coordinate-domain sync/active terms delayed to match the
// renderer latency, and a final output register for RGB, DE and syncs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE   = VGA_H_VISIBLE,
    parameter int H_FRONT     = VGA_H_FRONT,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BACK      = VGA_H_BACK,
    parameter int V_VISIBLE   = VGA_V_VISIBLE,
    parameter int V_FRONT     = VGA_V_FRONT,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BACK      = VGA_V_BACK,
    parameter int RGB_LATENCY = 1
) (
    input  logic               px_clk,
    input  logic               reset_ni,
    input  logic [COLOR_W-1:0] red_i,
    input  logic [COLOR_W-1:0] green_i,
    input  logic [COLOR_W-1:0] blue_i,
    output logic [CNT_W-1:0]   x_o,
    output logic [CNT_W-1:0]   y_o,
    output logic               frame_o,
    output logic               de_o,
    output logic [COLOR_W-1:0] red_o,
    output logic [COLOR_W-1:0] green_o,
    output logic [COLOR_W-1:0] blue_o,
    output logic               hsync_o,
    output logic               vsync_o
);

    localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int CW1   = CNT_W + 1;

    if (H_TOT > CNT_LIMIT) begin : g_h_range_chk
        $error("vga_timing_gen: horizontal total exceeds counter range");
    end
    if (V_TOT > CNT_LIMIT) begin : g_v_range_chk
        $error("vga_timing_gen: vertical total exceeds counter range");
    end

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);

    // One extra bit so a sync window ending exactly at 1024 still compares correctly.
    localparam logic [CW1-1:0] H_ACT_END = CW1'(H_VISIBLE);
    localparam logic [CW1-1:0] HS_BEG    = CW1'(H_VISIBLE + H_FRONT);
    localparam logic [CW1-1:0] HS_END    = CW1'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CW1-1:0] V_ACT_END = CW1'(V_VISIBLE);
    localparam logic [CW1-1:0] VS_BEG    = CW1'(V_VISIBLE + V_FRONT);
    localparam logic [CW1-1:0] VS_END    = CW1'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] h, v;
    logic [CW1-1:0]   h_ext, v_ext;
    sync_t            coord, dly;

    always_ff @(posedge px_clk or negedge reset_ni) begin
        if (!reset_ni) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    assign x_o     = h;
    assign y_o     = v;
    assign frame_o = (h == '0) && (v == '0);

    assign h_ext = {1'b0, h};
    assign v_ext = {1'b0, v};

    always_comb begin
        coord         = SYNC_IDLE;
        coord.active  = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
        coord.hsync_n = !((h_ext >= HS_BEG) && (h_ext < HS_END));
        coord.vsync_n = !((v_ext >= VS_BEG) && (v_ext < VS_END));
    end

    // Hold the timing terms back until the renderer's colour for the same pixel arrives.
    sync_delay #(
        .WIDTH   ($bits(sync_t)),
        .DEPTH   (RGB_LATENCY),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .px_clk   (px_clk),
        .reset_ni (reset_ni),
        .d        (coord),
        .q        (dly)
    );

    always_ff @(posedge px_clk or negedge reset_ni) begin
        if (!reset_ni) begin
            de_o    <= 1'b0;
            red_o   <= '0;
            green_o <= '0;
            blue_o  <= '0;
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
        end else begin
            de_o    <= dly.active;
            red_o   <= dly.active ? red_i   : '0;
            green_o <= dly.active ? green_i : '0;
            blue_o  <= dly.active ? blue_i  : '0;
            hsync_o <= dly.hsync_n;
            vsync_o <= dly.vsync_n;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny zero-latency instance,
// both compared every cycle against an arithmetic raster model, plus spot vectors and an async reset.
module tb_vga_timing_gen;

    logic px_clk = 1'b0;
    logic reset_ni;
    always #5 px_clk = ~px_clk;

    logic [3:0] r_m, g_m, b_m, ro_m, go_m, bo_m;
    logic [9:0] x_m, y_m;
    logic       frame_m, de_m, hs_m, vs_m;

    logic [3:0] r_s, g_s, b_s, ro_s, go_s, bo_s;
    logic [9:0] x_s, y_s;
    logic       frame_s, de_s, hs_s, vs_s;

    vga_timing_gen dut (
        .px_clk (px_clk), .reset_ni (reset_ni),
        .red_i (r_m), .green_i (g_m), .blue_i (b_m),
        .x_o (x_m), .y_o (y_m), .frame_o (frame_m), .de_o (de_m),
        .red_o (ro_m), .green_o (go_m), .blue_o (bo_m),
        .hsync_o (hs_m), .vsync_o (vs_m)
    );

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
        .RGB_LATENCY (0)
    ) dut_s (
        .px_clk (px_clk), .reset_ni (reset_ni),
        .red_i (r_s), .green_i (g_s), .blue_i (b_s),
        .x_o (x_s), .y_o (y_s), .frame_o (frame_s), .de_o (de_s),
        .red_o (ro_s), .green_o (go_s), .blue_o (bo_s),
        .hsync_o (hs_s), .vsync_o (vs_s)
    );

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        frame;
        logic        de;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } out_t;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb, lat;
    } tim_t;

    typedef struct {
        int         k;
        logic       frame;
        logic       de;
        logic [3:0] red;
        logic       hs;
    } vec_t;

    tim_t TM = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
    tim_t TS = '{8, 2, 3, 2, 4, 1, 2, 1, 0};

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;
    int   hs_low_m, hs_high_m, frames_m, frames_s, vs_low_s;
    logic [11:0] prev_m, prev_s;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Raster position from the cycle count since reset release; outputs trail by lat+1 cycles.
    function automatic out_t model(input int k, input tim_t p, input logic [11:0] prev);
        int   ht, vt, c, ch, cv;
        out_t o;
        ht      = p.hv + p.hf + p.hs + p.hb;
        vt      = p.vv + p.vf + p.vs + p.vb;
        o       = '0;
        o.x     = 10'(k % ht);
        o.y     = 10'((k / ht) % vt);
        o.frame = (k % (ht * vt)) == 0;
        o.hs    = 1'b1;
        o.vs    = 1'b1;
        c       = k - 1 - p.lat;
        if (c >= 0) begin
            ch    = c % ht;
            cv    = (c / ht) % vt;
            o.de  = (ch < p.hv) && (cv < p.vv);
            o.hs  = !((ch >= p.hv + p.hf) && (ch < p.hv + p.hf + p.hs));
            o.vs  = !((cv >= p.vv + p.vf) && (cv < p.vv + p.vf + p.vs));
            o.rgb = o.de ? prev : 12'h0;
        end
        return o;
    endfunction

    // Called at the falling edge that opens cycle 0 just after reset release.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            out_t am, as_, em, es;
            am = {x_m, y_m, frame_m, de_m, ro_m, go_m, bo_m, hs_m, vs_m};
            as_ = {x_s, y_s, frame_s, de_s, ro_s, go_s, bo_s, hs_s, vs_s};
            em = model(k, TM, prev_m);
            es = model(k, TS, prev_s);
            chk("main_model", am, em);
            chk("small_model", as_, es);
            foreach (vecs[i]) begin
                if (vecs[i].k == k) begin
                    chk($sformatf("vec_k%0d", k),
                        {frame_m, de_m, ro_m, hs_m},
                        {vecs[i].frame, vecs[i].de, vecs[i].red, vecs[i].hs});
                end
            end
            if (k >= 800 && k < 1600) begin
                if (hs_m) hs_high_m++; else hs_low_m++;
            end
            if (k >= 120 && k < 240 && !vs_s) vs_low_s++;
            if (frame_m) frames_m++;
            if (frame_s) frames_s++;
            // Renderer stand-in: red follows x_o one cycle late, green pinned at full scale.
            r_m    = (k == 0) ? 4'h0 : 4'(((k - 1) % 800) & 15);
            g_m    = 4'hf;
            b_m    = 4'($urandom_range(0, 15));
            prev_m = {r_m, g_m, b_m};
            {r_s, g_s, b_s} = 12'($urandom);
            prev_s = {r_s, g_s, b_s};
            @(negedge px_clk);
        end
    endtask

    initial begin
        vecs.push_back('{0,   1'b1, 1'b0, 4'd0,  1'b1});
        vecs.push_back('{1,   1'b0, 1'b0, 4'd0,  1'b1});
        vecs.push_back('{2,   1'b0, 1'b1, 4'd0,  1'b1});
        vecs.push_back('{3,   1'b0, 1'b1, 4'd1,  1'b1});
        vecs.push_back('{641, 1'b0, 1'b1, 4'd15, 1'b1});
        vecs.push_back('{642, 1'b0, 1'b0, 4'd0,  1'b1});
        vecs.push_back('{657, 1'b0, 1'b0, 4'd0,  1'b1});
        vecs.push_back('{658, 1'b0, 1'b0, 4'd0,  1'b0});
        vecs.push_back('{753, 1'b0, 1'b0, 4'd0,  1'b0});
        vecs.push_back('{754, 1'b0, 1'b0, 4'd0,  1'b1});
        vecs.push_back('{800, 1'b0, 1'b0, 4'd0,  1'b1});
        vecs.push_back('{802, 1'b0, 1'b1, 4'd0,  1'b1});

        reset_ni = 1'b0;
        {r_m, g_m, b_m} = 12'hfff;
        {r_s, g_s, b_s} = 12'hfff;
        prev_m = '0;
        prev_s = '0;
        repeat (3) @(negedge px_clk);
        chk("rst_main", {x_m, y_m, de_m, ro_m, go_m, bo_m, hs_m, vs_m}, {20'h0, 1'b0, 12'h0, 2'b11});
        chk("rst_small", {x_s, y_s, de_s, ro_s, go_s, bo_s, hs_s, vs_s}, {20'h0, 1'b0, 12'h0, 2'b11});

        hs_low_m = 0; hs_high_m = 0; frames_m = 0; frames_s = 0; vs_low_s = 0;
        reset_ni = 1'b1;
        run(3100);
        chk("hsync_low_cycles", hs_low_m, 96);
        chk("hsync_high_cycles", hs_high_m, 704);
        chk("main_frame_pulses", frames_m, 1);
        chk("small_frame_pulses", frames_s, 26);
        chk("small_vsync_low_cycles", vs_low_s, 30);

        // Now at x_o=700, inside hsync: reset must act without waiting for a clock edge.
        chk("pre_rst_x", x_m, 700);
        chk("pre_rst_hsync", hs_m, 0);
        #2 reset_ni = 1'b0;
        #1;
        chk("async_rst_hsync", hs_m, 1);
        chk("async_rst_rgb_de", {de_m, ro_m, go_m, bo_m}, 13'h0);
        chk("async_rst_xy", {x_m, y_m}, 20'h0);
        chk("async_rst_small", {x_s, y_s, de_s, hs_s, vs_s}, {20'h0, 3'b011});
        repeat (3) @(negedge px_clk);
        hs_low_m = 0; hs_high_m = 0; frames_m = 0; frames_s = 0; vs_low_s = 0;
        reset_ni = 1'b1;
        run(900);
        chk("restart_frame_pulses", frames_m, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
